instr_fetch: RTL

- Fetch stage of the RV32I core; sits directly upstream of the decode/immediate-generation logic.
- Owns the program counter and issues word requests to instruction memory (one outstanding request at most).
- Latches the returned word into an instruction register and presents it with a valid/stall handshake.
- Instr[31:7] from this block drives the immediate generator; PC and PCPlus4 feed the branch/jump target adders.

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/instr_fetch.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants and types for the RV32I core.
// Fetch-stage state encoding and the canonical NOP live here.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP,
    VALID
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage. Owns the PC, issues one word request
// at a time and presents the returned word with a valid/stall handshake.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Fault
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;
  logic            r_fault;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_instr_nxt;
  logic            w_valid_nxt;
  logic            w_fault_nxt;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_req_pc;
  logic            w_req;
  logic            w_pc_mis;
  logic            w_inc_mis;

  assign w_pc_inc  = r_pc + 32'd4;
  assign w_pc_mis  = |r_pc[1:0];
  assign w_inc_mis = |w_pc_inc[1:0];

  // Next-state, next-PC mux and request strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    w_req       = 1'b0;
    w_req_pc    = r_pc;
    unique case (r_state)
      FETCH: begin
        if (w_pc_mis) begin
          // A misaligned target never reaches memory; present a faulting NOP.
          if (Redirect) begin
            w_pc_nxt = RedirectPC;
          end else begin
            w_state_nxt = VALID;
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b1;
            w_fault_nxt = 1'b1;
          end
        end else begin
          w_req = 1'b1;
          if (Redirect) begin
            w_pc_nxt    = RedirectPC;
            w_state_nxt = DROP;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (Redirect) begin
          w_pc_nxt    = RedirectPC;
          w_state_nxt = IMemRValid ? FETCH : DROP;
        end else if (IMemRValid) begin
          w_instr_nxt = IMemRData;
          w_valid_nxt = 1'b1;
          w_state_nxt = VALID;
        end
      end
      DROP: begin
        if (Redirect) begin
          w_pc_nxt = RedirectPC;
        end
        if (IMemRValid) begin
          w_state_nxt = FETCH;
        end
      end
      VALID: begin
        if (Redirect) begin
          w_pc_nxt    = RedirectPC;
          w_instr_nxt = NOP_INSTR;
          w_valid_nxt = 1'b0;
          w_fault_nxt = 1'b0;
          w_state_nxt = FETCH;
        end else if (!Stall) begin
          w_pc_nxt    = w_pc_inc;
          w_instr_nxt = NOP_INSTR;
          w_valid_nxt = 1'b0;
          w_fault_nxt = 1'b0;
          // Sequential fetch after a faulting PC stays misaligned:
          // let FETCH raise the fault again rather than request memory.
          if (w_inc_mis) begin
            w_state_nxt = FETCH;
          end else begin
            w_req       = 1'b1;
            w_req_pc    = w_pc_inc;
            w_state_nxt = WAIT;
          end
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
    if (reset) begin
      w_req = 1'b0;
    end
  end

  // State, PC and instruction register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign IMemReq    = w_req;
  assign IMemAddr   = {w_req_pc[31:2], 2'b00};
  assign InstrValid = r_valid;
  assign Instr      = r_instr;
  assign PC         = r_pc;
  assign PCPlus4    = w_pc_inc;
  assign Fault      = r_fault;

endmodule
